// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-path constants and the {instr, pc} queue entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry {instr, pc} prefetch queue; push_i/pop_i/flush_i in, head_o/count_o out
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  assign head_o = mem_q[rd_q];
  assign count_o = count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) mem_q[wr_q] <= data_i;
      wr_q <= wr_q + AW'(push_i);
      rd_q <= rd_q + AW'(pop_i);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential PC fetch over valid/ready imem, prefetch queue to decode, redirect flush
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] out_q, out_d, discard_q, discard_d, count;
  logic req_fire, push, pop;
  fetch_entry_t head;
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign imem_req_valid = !reset && !redirect && (({1'b0, out_q} + {1'b0, count}) < (CW+1)'(DEPTH));
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && discard_q == '0 && !redirect;
  assign pop = instr_valid && instr_ready && !redirect;
  assign imem_addr = fetch_pc_q;
  assign instr_valid = count != '0;
  assign instr = head.instr;
  assign instr_pc = head.pc;
  always_comb begin
    fetch_pc_d = redirect ? target : req_fire ? fetch_pc_q + XLEN'(INSTR_BYTES) : fetch_pc_q;
    rsp_pc_d = redirect ? target : push ? rsp_pc_q + XLEN'(INSTR_BYTES) : rsp_pc_q;
    out_d = out_q + CW'(req_fire) - CW'(imem_rsp_valid);
    discard_d = redirect ? out_d : discard_q - CW'(imem_rsp_valid && discard_q != '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= START_PC;
      rsp_pc_q <= START_PC;
      out_q <= '0;
      discard_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q <= out_d;
      discard_q <= discard_d;
    end
  end
  always_ff @(posedge clk) if (!reset && imem_rsp_valid) assert (out_q != '0 || req_fire);
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(reset),
    .push_i(push),
    .data_i({imem_rdata, rsp_pc_q}),
    .pop_i(pop),
    .flush_i(redirect),
    .head_o(head),
    .count_o(count)
  );
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of decode and immediate extension. Generates sequential 32-bit word addresses from a PC register and issues them to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Buffers returned instructions with their PCs in a small prefetch queue and presents them to decode, whose `instr[31:7]` feeds the immediate extender. Handles taken-branch/jump redirects by flushing the queue and discarding in-flight responses.

## Interface
- `DEPTH`, default 2: prefetch queue entries; also the maximum number of outstanding-plus-buffered fetches (power of two, ≥2).
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_addr` out 32: word address of the request; bits [1:0] always 0.
- `imem_rsp_valid` in 1: response valid; one per accepted request, in order.
- `imem_rdata` in 32: fetched instruction.
- `instr_valid` out 1: queue head valid to decode.
- `instr_ready` in 1: decode consumes head.
- `instr` out 32: head instruction.
- `instr_pc` out 32: head instruction's PC.
- `redirect` in 1: taken branch/jump; 1-cycle pulse.
- `redirect_pc` in 32: new fetch PC; bits [1:0] ignored (treated as 0).

## Operation
- State: `fetch_pc` (next request address), `rsp_pc` (PC of next kept response), `outstanding` (accepted, not yet returned), `discard` (stale responses still to drop), queue of {instr, pc}.
- Credit rule: `imem_req_valid` = !reset-state && !redirect && (outstanding + occupancy < DEPTH). Independent of `imem_req_ready`.
- Request accepted (`imem_req_valid && imem_req_ready`): `fetch_pc += 4`, `outstanding += 1`.
- Response: `outstanding -= 1`; if `discard > 0` then `discard -= 1`, data dropped; else enqueue {`imem_rdata`, `rsp_pc`}, `rsp_pc += 4`.
- Dequeue on `instr_valid && instr_ready`.
- Redirect (highest priority): queue flushed; `fetch_pc` and `rsp_pc` ← {`redirect_pc[31:2]`, 2'b00}; `discard` ← outstanding − (`imem_rsp_valid` ? 1 : 0) + `discard`-adjust, i.e. every response still in flight after this cycle is dropped; any response arriving this cycle is dropped; no request issued this cycle.
- PC arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0 silently.
- Simultaneous enqueue and dequeue when full is legal; credit rule guarantees the queue never overflows, so no overflow path exists.
- Response with `outstanding == 0` is a protocol error; assertion only, not handled.

## Timing
- Reset values: `imem_req_valid` 0, `imem_addr` RESET_PC, `instr_valid` 0, `instr` 0, `instr_pc` 0; counters 0.
- First request asserted the first cycle after `reset` deasserts.
- Response to `instr_valid`: 1 cycle (response registered into queue; no bypass).
- Freed slot (dequeue or response) raises `imem_req_valid` the following cycle, not combinationally.
- Redirect at cycle N: `instr_valid` 0 at N+1; first request to new PC at N+1.
- `imem_addr` and `instr`/`instr_pc` driven from registers; `imem_req_valid` combinational from registers plus `redirect`.
- Reset mid-operation clears queue and counters immediately; in-flight memory responses after reset are the memory's responsibility (memory reset together).

## Structure
- Shared `riscv_pkg`: `XLEN` = 32, `INSTR_BYTES` = 4, `fetch_entry_t` struct {instr, pc}.
- One sub-module: `fetch_fifo` (parameterised DEPTH, `fetch_entry_t` data, push/pop/flush, count output).

## Test plan
- Reset then zero-latency memory, `instr_ready` held 1: instrs at PC 0x0, 0x4, 0x8… one per cycle after 2-cycle startup.
- `instr_ready` held 0: exactly 2 requests (0x0, 0x4) issued, `imem_req_valid` then 0; release → 0x8 requested next cycle.
- Memory latency 3, redirect to 0x0000_0103 with 2 outstanding: both stale responses dropped, next `instr_pc` 0x0000_0100.
- Redirect in same cycle as response and dequeue: response dropped, queue empty next cycle, request to new PC next cycle.
- `imem_req_ready` randomly toggled: `instr_pc` strictly +4 sequence, data matches memory model.
- Redirect to 0xFFFF_FFFC: requests 0xFFFF_FFFC then 0x0000_0000.
